// File: rtl/sdrc_multiport_arb.sv
// sdrc_multiport_arb: multi-channel request arbiter in front of an SDRAM controller.
// Round-robin by default; define SDRC_ARB_FIXED_PRIO_EN for lowest-index priority.
module sdrc_multiport_arb #(
    parameter int NCH    = 4,
    parameter int APP_AW = 26,
    parameter int dw     = 32,
    parameter int bl     = 9
) (
    input  logic                    sdram_clk,
    input  logic                    sdram_resetn,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH*APP_AW-1:0]   ch_req_addr,
    input  logic [NCH*bl-1:0]       ch_req_len,
    input  logic [NCH-1:0]          ch_req_wr_n,
    output logic [NCH-1:0]          ch_req_ack,
    input  logic [NCH*dw-1:0]       ch_wr_data,
    input  logic [NCH*(dw/8)-1:0]   ch_wr_en_n,
    output logic [NCH-1:0]          ch_wr_next,
    output logic [NCH-1:0]          ch_rd_valid,
    output logic [NCH-1:0]          ch_last_rd,
    output logic [dw-1:0]           ch_rd_data,
    output logic                    app_req,
    output logic [APP_AW-1:0]       app_req_addr,
    output logic [bl-1:0]           app_req_len,
    output logic                    app_req_wr_n,
    input  logic                    app_req_ack,
    output logic [dw-1:0]           app_wr_data,
    output logic [dw/8-1:0]         app_wr_en_n,
    input  logic                    app_wr_next_req,
    input  logic [dw-1:0]           app_rd_data,
    input  logic                    app_rd_valid,
    input  logic                    app_last_rd,
    input  logic                    app_last_wr,
    output logic                    arb_busy,
    output logic [$clog2(NCH)-1:0]  arb_gnt_id
);

    localparam int GW = $clog2(NCH);
    localparam int BW = dw / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WR,
        RD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   gnt_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   rr_nxt;
    logic [GW-1:0]   rr_ret;
    logic [GW-1:0]   win;
    logic            found;
    logic            any_req;
    logic [NCH-1:0]  gnt_oh;
    int              j;

    assign any_req    = |ch_req;
    assign gnt_oh     = NCH'(1) << gnt;
    assign arb_busy   = (state != IDLE);
    assign arb_gnt_id = gnt;

    // Read data is a shared bus; it is only forced quiet while reset is held.
    assign ch_rd_data = sdram_resetn ? app_rd_data : '0;

`ifdef SDRC_ARB_FIXED_PRIO_EN
    assign rr_ret = '0;
`else
    assign rr_ret = (gnt == GW'(NCH - 1)) ? '0 : gnt + 1'b1;
`endif

    // Pick the first requester at or above rr_ptr, wrapping past NCH-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!found && ch_req[j]) begin
                found = 1'b1;
                win   = GW'(j);
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Next-state logic and per-state routing between granted channel and controller.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rr_nxt       = rr_ptr;
        app_req      = 1'b0;
        app_req_addr = '0;
        app_req_len  = '0;
        app_req_wr_n = 1'b0;
        app_wr_data  = '0;
        app_wr_en_n  = '1;
        ch_req_ack   = '0;
        ch_wr_next   = '0;
        ch_rd_valid  = '0;
        ch_last_rd   = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_nxt   = win;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                app_req      = 1'b1;
                app_req_addr = ch_req_addr[int'(gnt)*APP_AW +: APP_AW];
                app_req_len  = ch_req_len[int'(gnt)*bl +: bl];
                app_req_wr_n = ch_req_wr_n[gnt];
                if (app_req_ack) begin
                    ch_req_ack = gnt_oh;
                    state_nxt  = ch_req_wr_n[gnt] ? RD : WR;
                end
            end
            WR: begin
                app_wr_data = ch_wr_data[int'(gnt)*dw +: dw];
                app_wr_en_n = ch_wr_en_n[int'(gnt)*BW +: BW];
                if (app_wr_next_req) begin
                    ch_wr_next = gnt_oh;
                    if (app_last_wr) begin
                        state_nxt = IDLE;
                        rr_nxt    = rr_ret;
                    end
                end
            end
            RD: begin
                if (app_rd_valid) begin
                    ch_rd_valid = gnt_oh;
                    if (app_last_rd) begin
                        ch_last_rd = gnt_oh;
                        state_nxt  = IDLE;
                        rr_nxt     = rr_ret;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdrc_multiport_arb.sv
// tb_sdrc_multiport_arb: randomized bench for sdrc_multiport_arb.
// Channel/controller agents plus a queue-level arbitration model.
module tb_sdrc_multiport_arb;

    localparam int NCH = 4;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int BL  = 9;
    localparam int BW  = DW / 8;
    localparam int GW  = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       ch_req;
    logic [NCH*AW-1:0]    ch_req_addr;
    logic [NCH*BL-1:0]    ch_req_len;
    logic [NCH-1:0]       ch_req_wr_n;
    logic [NCH-1:0]       ch_req_ack;
    logic [NCH*DW-1:0]    ch_wr_data;
    logic [NCH*BW-1:0]    ch_wr_en_n;
    logic [NCH-1:0]       ch_wr_next;
    logic [NCH-1:0]       ch_rd_valid;
    logic [NCH-1:0]       ch_last_rd;
    logic [DW-1:0]        ch_rd_data;
    logic                 app_req;
    logic [AW-1:0]        app_req_addr;
    logic [BL-1:0]        app_req_len;
    logic                 app_req_wr_n;
    logic                 app_req_ack;
    logic [DW-1:0]        app_wr_data;
    logic [BW-1:0]        app_wr_en_n;
    logic                 app_wr_next_req;
    logic [DW-1:0]        app_rd_data;
    logic                 app_rd_valid;
    logic                 app_last_rd;
    logic                 app_last_wr;
    logic                 arb_busy;
    logic [GW-1:0]        arb_gnt_id;

    sdrc_multiport_arb #(
        .NCH(NCH), .APP_AW(AW), .dw(DW), .bl(BL)
    ) dut (
        .sdram_clk       (clk),
        .sdram_resetn    (rst_n),
        .ch_req          (ch_req),
        .ch_req_addr     (ch_req_addr),
        .ch_req_len      (ch_req_len),
        .ch_req_wr_n     (ch_req_wr_n),
        .ch_req_ack      (ch_req_ack),
        .ch_wr_data      (ch_wr_data),
        .ch_wr_en_n      (ch_wr_en_n),
        .ch_wr_next      (ch_wr_next),
        .ch_rd_valid     (ch_rd_valid),
        .ch_last_rd      (ch_last_rd),
        .ch_rd_data      (ch_rd_data),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_ack     (app_req_ack),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_data     (app_rd_data),
        .app_rd_valid    (app_rd_valid),
        .app_last_rd     (app_last_rd),
        .app_last_wr     (app_last_wr),
        .arb_busy        (arb_busy),
        .arb_gnt_id      (arb_gnt_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit           pend   [NCH];
    logic [AW-1:0] m_addr [NCH];
    logic [BL-1:0] m_len  [NCH];
    bit           m_wr_n [NCH];
    int           m_rr;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int i, input int len, input bit wr_n,
                           input logic [AW-1:0] addr);
        pend[i]   = 1'b1;
        m_addr[i] = addr;
        m_len[i]  = BL'(len);
        m_wr_n[i] = wr_n;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NCH; i++) begin
            ch_req[i]                = pend[i];
            ch_req_addr[i*AW +: AW]  = m_addr[i];
            ch_req_len[i*BL +: BL]   = m_len[i];
            ch_req_wr_n[i]           = m_wr_n[i];
        end
    endtask

    task automatic rand_wr_side();
        for (int i = 0; i < NCH; i++) begin
            ch_wr_data[i*DW +: DW] = $urandom;
            ch_wr_en_n[i*BW +: BW] = BW'($urandom);
        end
    endtask

    // Expected winner from the arbitration rule, walking the pending set.
    function automatic int pick();
        int start;
`ifdef SDRC_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_rr;
`endif
        for (int k = 0; k < NCH; k++) begin
            if (pend[(start + k) % NCH]) return (start + k) % NCH;
        end
        return -1;
    endfunction

    task automatic strays();
        app_rd_valid    = 1'($urandom);
        app_wr_next_req = 1'($urandom);
        app_last_rd     = 1'($urandom);
        app_last_wr     = 1'($urandom);
        app_rd_data     = $urandom;
    endtask

    task automatic run_txn(input int abort_at, output int w, output int words);
        int gaps;
        int cyc;
        bit beat;
        bit last;
        bit done;
        logic [NCH-1:0] oh;
        w     = pick();
        words = 0;
        oh    = NCH'(1) << w;
        drive_req();
        app_req_ack = 1'b0;
        strays();
        #1;
        chk("idle_busy", arb_busy, 0);
        chk("idle_app_req", app_req, 0);
        chk("idle_rd_valid", ch_rd_valid, 0);
        chk("idle_last_rd", ch_last_rd, 0);
        chk("idle_wr_next", ch_wr_next, 0);
        chk("idle_ack", ch_req_ack, 0);
        chk("idle_wr_en_n", app_wr_en_n, {BW{1'b1}});
        chk("idle_rd_data", ch_rd_data, app_rd_data);
        next_cyc();
        gaps = $urandom_range(0, 3);
        for (int g = 0; g <= gaps; g++) begin
            app_req_ack = (g == gaps);
            strays();
            #1;
            chk("req_gnt", arb_gnt_id, w);
            chk("req_app_req", app_req, 1);
            chk("req_busy", arb_busy, 1);
            chk("req_addr", app_req_addr, m_addr[w]);
            chk("req_len", app_req_len, m_len[w]);
            chk("req_wr_n", app_req_wr_n, m_wr_n[w]);
            chk("req_ack", ch_req_ack, app_req_ack ? oh : '0);
            chk("req_rd_valid", ch_rd_valid, 0);
            chk("req_wr_next", ch_wr_next, 0);
            next_cyc();
        end
        pend[w]     = 1'b0;
        app_req_ack = 1'b0;
        drive_req();
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 200) begin
            if (abort_at >= 0 && words == abort_at) return;
            beat = ($urandom_range(0, 3) != 0);
            last = beat && (words == int'(m_len[w]) - 1);
            rand_wr_side();
            app_rd_data = $urandom;
            if (!m_wr_n[w]) begin
                app_wr_next_req = beat;
                app_last_wr     = last || (!beat && 1'($urandom));
                app_rd_valid    = 1'b0;
                app_last_rd     = 1'b0;
                #1;
                chk("wr_data", app_wr_data, ch_wr_data[w*DW +: DW]);
                chk("wr_en_n", app_wr_en_n, ch_wr_en_n[w*BW +: BW]);
                chk("wr_next", ch_wr_next, beat ? oh : '0);
                chk("wr_rd_valid", ch_rd_valid, 0);
            end else begin
                app_rd_valid    = beat;
                app_last_rd     = last || (!beat && 1'($urandom));
                app_wr_next_req = 1'b0;
                app_last_wr     = 1'b0;
                #1;
                chk("rd_valid", ch_rd_valid, beat ? oh : '0);
                chk("rd_last", ch_last_rd, last ? oh : '0);
                chk("rd_data", ch_rd_data, app_rd_data);
                chk("rd_wr_en_n", app_wr_en_n, {BW{1'b1}});
                chk("rd_wr_data", app_wr_data, 0);
            end
            chk("data_busy", arb_busy, 1);
            chk("data_app_req", app_req, 0);
            if (beat) words++;
            if (last) done = 1'b1;
            next_cyc();
            cyc++;
        end
        if (!done) chk("data_timeout", 0, 1);
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
`ifndef SDRC_ARB_FIXED_PRIO_EN
        m_rr = (w + 1) % NCH;
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, arb_busy, 0);
        chk({tag, "_gnt"}, arb_gnt_id, 0);
        chk({tag, "_app_req"}, app_req, 0);
        chk({tag, "_addr"}, app_req_addr, 0);
        chk({tag, "_len"}, app_req_len, 0);
        chk({tag, "_wr_n"}, app_req_wr_n, 0);
        chk({tag, "_wr_data"}, app_wr_data, 0);
        chk({tag, "_wr_en_n"}, app_wr_en_n, {BW{1'b1}});
        chk({tag, "_ack"}, ch_req_ack, 0);
        chk({tag, "_wr_next"}, ch_wr_next, 0);
        chk({tag, "_rd_valid"}, ch_rd_valid, 0);
        chk({tag, "_last_rd"}, ch_last_rd, 0);
        chk({tag, "_rd_data"}, ch_rd_data, 0);
    endtask

    initial begin
        int w;
        int words;
        int any;
        int rr_exp [3];
        rr_exp[0] = 0;
        rr_exp[1] = 1;
        rr_exp[2] = 3;
        m_rr = 0;
        for (int i = 0; i < NCH; i++) begin
            pend[i]   = 1'b0;
            m_addr[i] = '0;
            m_len[i]  = '0;
            m_wr_n[i] = 1'b0;
        end
        rst_n           = 1'b0;
        drive_req();
        rand_wr_side();
        ch_req          = '1;
        app_req_ack     = 1'b1;
        app_wr_next_req = 1'b1;
        app_rd_valid    = 1'b1;
        app_last_rd     = 1'b1;
        app_last_wr     = 1'b1;
        app_rd_data     = 32'hdead_beef;
        #22;
        chk_reset_outputs("por");
        drive_req();
        app_req_ack     = 1'b0;
        app_wr_next_req = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
        app_last_wr     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();

        new_req(0, 1, 1'b1, AW'(26'h0000100));
        new_req(1, 1, 1'b1, AW'(26'h0000200));
        new_req(3, 1, 1'b1, AW'(26'h0000300));
        for (int t = 0; t < 3; t++) begin
            run_txn(-1, w, words);
            chk("rr_order", w, rr_exp[t]);
            chk("rr_words", words, 1);
        end

        new_req(2, 4, 1'b0, AW'(26'h0001234));
        run_txn(-1, w, words);
        chk("wr_gnt", w, 2);
        chk("wr_words", words, 4);

        new_req(1, 8, 1'b1, AW'($urandom));
        run_txn(-1, w, words);
        chk("rd_gnt", w, 1);
        chk("rd_words", words, 8);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    new_req(i, $urandom_range(1, 6), 1'($urandom), AW'($urandom));
            end
`ifdef SDRC_ARB_FIXED_PRIO_EN
            if (!pend[0]) new_req(0, $urandom_range(1, 4), 1'($urandom), AW'($urandom));
            if (!pend[2]) new_req(2, $urandom_range(1, 4), 1'($urandom), AW'($urandom));
`endif
            any = 0;
            for (int i = 0; i < NCH; i++) any += int'(pend[i]);
            if (any == 0)
                new_req($urandom_range(0, NCH - 1), $urandom_range(1, 6),
                        1'($urandom), AW'($urandom));
            run_txn(-1, w, words);
`ifdef SDRC_ARB_FIXED_PRIO_EN
            chk("fixed_no_ch2", (w == 2), 0);
`endif
        end

        for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
        new_req(3, 4, 1'b0, AW'($urandom));
        run_txn(2, w, words);
        chk("abort_words", words, 2);
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
        app_rd_data     = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        next_cyc();
        @(negedge clk);
        rst_n = 1'b1;
        m_rr  = 0;
        for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
        next_cyc();
        new_req(3, 2, 1'b1, AW'($urandom));
        run_txn(-1, w, words);
        chk("post_rst_gnt", w, 3);
        chk("post_rst_words", words, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
